// File: rtl/multi_channel_skid_slice.sv
// Multi-channel valid/ready pipeline slice with a 2-entry skid buffer, lane masking and init-done timer.
// Optional per-lane parity output enabled by defining MULTI_CHANNEL_SKID_SLICE_PARITY_EN.
module multi_channel_skid_slice #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int INIT_CYCLES = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_ch_en,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CHANNELS*WIDTH-1:0] o_data,
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
    output logic [CHANNELS-1:0]       o_parity,
`endif
    output logic                      o_init_done,
    output logic [1:0]                o_occupancy
);

    localparam int DW = CHANNELS * WIDTH;
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
    localparam int EW = DW + CHANNELS;
`else
    localparam int EW = DW;
`endif
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic            ready_q, ready_d;
    logic            init_done_q, init_done_d;
    logic [7:0]      init_cnt_q, init_cnt_d;
    logic [DW-1:0]   cap_data;
    logic [EW-1:0]   captured;
    logic            push;
    logic            pop;

    // Disabled lanes are stored as zero; parity (if present) rides along with the data word.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_ch_en[k]) begin
                cap_data[k*WIDTH +: WIDTH] = i_data[k*WIDTH +: WIDTH];
            end
        end
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
        captured[DW-1:0] = cap_data;
        for (int k = 0; k < CHANNELS; k++) begin
            captured[DW+k] = ^cap_data[k*WIDTH +: WIDTH];
        end
`else
        captured = cap_data;
`endif
    end

    assign push = i_valid & ready_q;
    assign pop  = (state_q != EMPTY) & i_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        init_cnt_d  = init_done_q ? init_cnt_q : init_cnt_q + 8'd1;
        init_done_d = init_done_q | (init_cnt_q == INIT_LAST);
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = captured;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                    skid_d  = captured;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    main_d = captured;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready is looked ahead one cycle so the upstream sees a pure flop output.
        ready_d = init_done_d & (state_d != TWO);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            init_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    always_comb begin
        o_occupancy = 2'd0;
        case (state_q)
            EMPTY:   o_occupancy = 2'd0;
            ONE:     o_occupancy = 2'd1;
            TWO:     o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

    assign o_valid     = (state_q != EMPTY);
    assign o_ready     = ready_q;
    assign o_data      = main_q[DW-1:0];
    assign o_init_done = init_done_q;
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
    assign o_parity    = main_q[EW-1:DW];
`endif

endmodule

// File: tb/tb_multi_channel_skid_slice.sv
// Directed, table-driven bench for multi_channel_skid_slice (INIT_CYCLES=3).
// Parity checks are compiled in when MULTI_CHANNEL_SKID_SLICE_PARITY_EN is defined.
module tb_multi_channel_skid_slice;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DW       = WIDTH * CHANNELS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic [3:0]    i_ch_en = 4'hF;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_init_done;
    logic [1:0]    o_occupancy;
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
    logic [3:0]    o_parity;
`endif

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [3:0]    ch_en;
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_occ;
        logic          exp_ready;
    } vec_t;

    vec_t vecs[16];

    multi_channel_skid_slice #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .INIT_CYCLES(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data(i_data),
        .i_ch_en(i_ch_en),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data(o_data),
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
        .o_parity(o_parity),
`endif
        .o_init_done(o_init_done),
        .o_occupancy(o_occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lane_parity(input logic [DW-1:0] d);
        logic [3:0] p;
        for (int k = 0; k < CHANNELS; k++) begin
            p[k] = ^d[k*WIDTH +: WIDTH];
        end
        return p;
    endfunction

    task automatic checkField(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input logic [DW-1:0] exp_data,
                               input logic [1:0] exp_occ, input logic exp_ready, input logic exp_init);
        checkField({tag, ".o_valid"}, DW'(o_valid), DW'(exp_valid));
        checkField({tag, ".o_occupancy"}, DW'(o_occupancy), DW'(exp_occ));
        checkField({tag, ".o_ready"}, DW'(o_ready), DW'(exp_ready));
        checkField({tag, ".o_init_done"}, DW'(o_init_done), DW'(exp_init));
        if (exp_valid) begin
            checkField({tag, ".o_data"}, o_data, exp_data);
`ifdef MULTI_CHANNEL_SKID_SLICE_PARITY_EN
            checkField({tag, ".o_parity"}, DW'(o_parity), DW'(lane_parity(exp_data)));
`endif
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic [3:0] en, input logic rdy);
        @(negedge clk);
        i_valid = valid;
        i_data  = data;
        i_ch_en = en;
        i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream, backpressure, lane mask and simultaneous push/pop in ONE.
        vecs[0]  = '{1'b1, 32'h11223344, 4'hF, 1'b1, 1'b1, 32'h11223344, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 32'h55667788, 4'hF, 1'b1, 1'b1, 32'h55667788, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'h99AABBCC, 4'hF, 1'b1, 1'b1, 32'h99AABBCC, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 32'h01020304, 4'hF, 1'b0, 1'b1, 32'h01020304, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 32'h05060708, 4'hF, 1'b0, 1'b1, 32'h01020304, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 32'h0BAD0BAD, 4'hF, 1'b0, 1'b1, 32'h01020304, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b1, 32'h05060708, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF, 4'b0101, 1'b0, 1'b1, 32'h00FF00FF, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 32'h01000000, 4'hF, 1'b1, 1'b1, 32'h01000000, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D, 2'd1, 1'b1};
        vecs[13] = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D, 2'd1, 1'b1};
        vecs[14] = '{1'b1, 32'h0D0D0D0D, 4'hF, 1'b1, 1'b1, 32'h0D0D0D0D, 2'd1, 1'b1};
        vecs[15] = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};

        // Reset values.
        #12;
        checkOutput("reset", 1'b0, '0, 2'd0, 1'b0, 1'b0);
        checkField("reset.o_data", o_data, '0);

        // Release reset with i_valid already high; nothing may be accepted before init completes.
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        i_ch_en = 4'hF;
        i_ready = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("init_edge%0d", e), 1'b0, '0, 2'd0, e == 3, e == 3);
        end

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ch_en, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_occ, vecs[i].exp_ready, 1'b1);
        end

        // Fill both entries, then reset asynchronously between clock edges.
        applyStimulus(1'b1, 32'hAAAA5555, 4'hF, 1'b0);
        applyStimulus(1'b1, 32'h5555AAAA, 4'hF, 1'b0);
        checkOutput("pre_reset", 1'b1, 32'hAAAA5555, 2'd2, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, '0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reinit_edge%0d", e), 1'b0, '0, 2'd0, e == 3, e == 3);
        end

        // Fresh data after reset; the pre-reset words must never appear.
        applyStimulus(1'b1, 32'h12345678, 4'hF, 1'b0);
        checkOutput("post_reset_push", 1'b1, 32'h12345678, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 4'hF, 1'b1);
        checkOutput("post_reset_pop", 1'b0, '0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 4'hF, 1'b1);
        checkOutput("post_reset_idle", 1'b0, '0, 2'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/multi_channel_skid_slice.md
Name: multi_channel_skid_slice

Overview:
- Parametrised multi-channel capture register with a valid/ready handshake on both sides and a 2-entry skid buffer, so the upstream ready is fully registered.
- Per-channel enable masking: disabled lanes are stored as zero.
- Registered init-done flag rises a programmable number of cycles after reset release.
- Sits between input pad/sync logic and downstream consumers as a generic pipeline stage.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 4, number of channel lanes (>=1)
- INIT_CYCLES, 1, clocks after reset deassertion before o_init_done=1 (>=1, <=255)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_valid  input  1  upstream data valid
- o_ready  output  1  slice can accept (registered)
- i_data  input  CHANNELS*WIDTH  upstream data; lane k = bits [k*WIDTH +: WIDTH]
- i_ch_en  input  CHANNELS  lane enable, sampled at accept
- o_valid  output  1  downstream data valid (registered)
- i_ready  input  1  downstream ready
- o_data  output  CHANNELS*WIDTH  downstream data (registered)
- o_init_done  output  1  initialisation complete
- o_occupancy  output  2  entries held, 0..2

Behaviour:
- Interface: one clock, i_clk; reset i_rst, asynchronous, active-high. All state clears immediately on i_rst=1.
- Reset values: o_ready=0, o_valid=0, o_data=0, o_init_done=0, o_occupancy=0, state=EMPTY, init counter=0.
- Init counter:
  - Increments each clock after i_rst falls.
  - o_init_done goes 1 on the INIT_CYCLES-th rising edge after release, then stays 1 until reset.
- Handshakes:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - i_data must be held stable while i_valid=1 and o_ready=0; the block does not check this.
- Captured word: lane k = i_data lane k when i_ch_en[k]=1, else 0.
- State machine, main and skid registers:
  - EMPTY: push -> ONE, main <= captured.
  - ONE: push & !pop -> TWO, skid <= captured.
  - ONE: pop & !push -> EMPTY.
  - ONE: push & pop -> ONE, main <= captured.
  - ONE: otherwise hold.
  - TWO: pop -> ONE, main <= skid.
  - TWO: push cannot occur (o_ready=0).
- Outputs:
  - o_valid = (state != EMPTY).
  - o_data = main. Main is not cleared on pop; stale data is permitted while o_valid=0.
  - o_ready = o_init_done & (next state != TWO), registered.
  - o_occupancy: EMPTY=0, ONE=1, TWO=2.
- Latency:
  - Accept on edge N gives o_valid=1 with that data after edge N (one cycle).
  - Order is strictly FIFO.
- Throughput: one word per cycle sustained when i_ready=1.
- Boundaries:
  - TWO with i_ready=0: data held indefinitely, o_ready=0.
  - Reset mid-transfer: both entries discarded; o_init_done drops and re-runs its count.
  - i_valid before o_init_done=1 is not accepted.

Optional Feature:
- Macro MULTI_CHANNEL_SKID_SLICE_PARITY_EN.
- Defined:
  - Adds output port o_parity, width CHANNELS: even parity (XOR reduction) per lane of the captured word.
  - Stored in main/skid alongside data, so it is aligned with o_data. Reset value 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Test Plan:
- Init timing: INIT_CYCLES=3; release i_rst at edge 0 -> o_init_done=1 and o_ready=1 after edge 3; i_valid=1 before that is not accepted.
- Stream: push 0x11223344, 0x55667788, 0x99AABBCC back-to-back with i_ready=1 -> same words on consecutive cycles, 1-cycle latency, o_occupancy stays 1.
- Backpressure: i_ready=0, push A=0x01020304, B=0x05060708 -> o_occupancy=2, o_ready=0, o_data=A. Then i_ready=1 -> A, then B, then o_valid=0.
- Lane mask: i_data=0xFFFFFFFF, i_ch_en=4'b0101 -> o_data=0x00FF00FF. With parity enabled, o_parity=4'b0000 for this word; i_data=0x01000000, i_ch_en=4'hF -> o_parity=4'b1000.
- Reset mid-operation: occupancy 2, assert i_rst asynchronously between edges -> o_valid, o_ready, o_occupancy, o_init_done all 0 immediately; after release, old data never reappears.
- Simultaneous push/pop in ONE: word C held, push D with i_ready=1 -> next cycle o_data=D, occupancy 1.
